// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with PC ownership and the IF/ID pipeline
//            register. Optional perf counters are built when
//            FETCH_PERF_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        ifid_inst,
    output logic [31:0]        ifid_pc_plus4,
    output logic               ifid_valid,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_flush
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = branch_target & ~32'd3;

    // Redirect beats stall so a taken branch is never lost behind a hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_ifid_inst     <= NOP_INST;
            r_ifid_pc_plus4 <= 32'd0;
            r_ifid_valid    <= 1'b0;
        end else if (branch_taken) begin
            r_pc            <= w_target;
            r_ifid_inst     <= NOP_INST;
            r_ifid_pc_plus4 <= 32'd0;
            r_ifid_valid    <= 1'b0;
        end else if (!stall) begin
            r_pc            <= w_pc_plus4;
            r_ifid_inst     <= imem_rdata;
            r_ifid_pc_plus4 <= w_pc_plus4;
            r_ifid_valid    <= 1'b1;
        end
    end

    assign imem_addr     = r_pc[IMEM_AW+1:2];
    assign pc            = r_pc;
    assign ifid_inst     = r_ifid_inst;
    assign ifid_pc_plus4 = r_ifid_pc_plus4;
    assign ifid_valid    = r_ifid_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
        end else if (branch_taken) begin
            r_perf_flush <= r_perf_flush + 32'd1;
        end else if (stall) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end else begin
            r_perf_fetch <= r_perf_fetch + 32'd1;
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
`else
    assign perf_fetch = 32'd0;
    assign perf_stall = 32'd0;
    assign perf_flush = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Scoreboard bench for fetch_stage: directed scenarios followed by
//            randomized stall/branch/reset traffic against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  addr;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] pfetch;
        logic [31:0] pstall;
        logic [31:0] pflush;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;

    logic [31:0] mem [256];
    exp_t        sb_q [$];
    int          checks;
    int          errors;

    // Reference model state, advanced once per issued cycle.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_pf;
    logic [31:0] m_ps;
    logic [31:0] m_pfl;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (8),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .ifid_inst     (ifid_inst),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .perf_fetch    (perf_fetch),
        .perf_stall    (perf_stall),
        .perf_flush    (perf_flush)
    );

    assign imem_rdata = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the state the model predicts after the next edge.
    task automatic issue(input logic r, input logic s, input logic b, input logic [31:0] t);
        exp_t e;
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        if (r) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_pf = 0; m_ps = 0; m_pfl = 0;
        end else if (b) begin
            m_pc    = (t / 4) * 4;
            m_inst  = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_pfl   = m_pfl + 1;
        end else if (s) begin
            m_ps = m_ps + 1;
        end else begin
            m_inst  = mem[(m_pc / 4) % 256];
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            m_pf    = m_pf + 1;
        end
        e.pc    = m_pc;
        e.addr  = 8'((m_pc / 4) % 256);
        e.inst  = m_inst;
        e.pc4   = m_pc4;
        e.valid = m_valid;
`ifdef FETCH_PERF_CNT_EN
        e.pfetch = m_pf;
        e.pstall = m_ps;
        e.pflush = m_pfl;
`else
        e.pfetch = 32'h0;
        e.pstall = 32'h0;
        e.pflush = 32'h0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        @(negedge clk);
        issue(r, s, b, t);
    endtask

    // Monitor: every edge's outcome is compared with the oldest pending prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc",            pc,                    e.pc);
                chk("imem_addr",     {24'h0, imem_addr},    {24'h0, e.addr});
                chk("ifid_inst",     ifid_inst,             e.inst);
                chk("ifid_pc_plus4", ifid_pc_plus4,         e.pc4);
                chk("ifid_valid",    {31'h0, ifid_valid},   {31'h0, e.valid});
                chk("perf_fetch",    perf_fetch,            e.pfetch);
                chk("perf_stall",    perf_stall,            e.pstall);
                chk("perf_flush",    perf_flush,            e.pflush);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_pf = 0; m_ps = 0; m_pfl = 0;

        // Reset for two edges, then sequential fetch of mem[0..3].
        issue(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // Three stall cycles, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // Redirect to 0x40 then fetch.
        step(1'b0, 1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // Branch and stall together with unaligned target.
        step(1'b0, 1'b1, 1'b1, 32'h23);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // Reset arriving during a stall, and during a branch.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h80);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic        r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 49) == 0);
            b = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       t = $urandom;
                default: t = 32'($urandom_range(0, 1023));
            endcase
            step(r, s, b, t);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
